pic_isr_ctrl: RTL and testbench
===============================

// Module: pic_isr_ctrl
// PURPOSE
//  Clocked, parametrised In-Service Register (ISR) controller for the 8259-style PIC.
//  Sets the ISR bit on the first INTA pulse and clears it on auto-EOI (second INTA) or on an OCW2 EOI command.
//  Non-specific EOI clears the highest-priority in-service bit, optionally under rotating priority.
//  Sits between the priority resolver (grant_idx) and the control/cascade logic.
// PARAMETERS
//  NUM_IRQ  8                      number of interrupt channels (2..32)
//  IDX_W    $clog2(NUM_IRQ)        index width (derived; do not override)
// PORTS
//  clk          in   1        system clock; all state changes on posedge
//  reset        in   1        synchronous, active-high reset
//  ack1         in   1        one-cycle strobe: first INTA pulse
//  ack2         in   1        one-cycle strobe: second INTA pulse
//  grant_idx    in   IDX_W    winning IRQ index from the priority resolver; sampled on ack1
//  aeoi_mode    in   1        1 = auto-EOI on ack2 (ICW4.AEOI)
//  eoi_cmd      in   1        one-cycle strobe: OCW2 EOI command
//  eoi_specific in   1        qualifies eoi_cmd: 1 = specific, 0 = non-specific
//  eoi_level    in   IDX_W    target index for a specific EOI
//  eoi_rotate   in   1        qualifies eoi_cmd: rotate priority on this EOI
//  aeoi_rotate  in   1        rotate priority on auto-EOI (OCW2 rotate-in-AEOI)
//  isr          out  NUM_IRQ  in-service bits
//  isr_any      out  1        OR-reduction of isr
//  isr_top_idx  out  IDX_W    highest-priority set isr bit; 0 when isr_any = 0
//  last_idx     out  IDX_W    index cleared by the most recent EOI or auto-EOI
//  last_valid   out  1        1 once any clear has occurred since reset
//  prio_base    out  IDX_W    index currently holding highest priority
// BEHAVIOUR
//  - Reset: isr = 0, last_idx = 0, last_valid = 0, prio_base = 0, FSM = IDLE. Reset wins over all strobes.
//  - All outputs are registered or derived from registers. A strobe sampled at edge N is visible after edge N.
//  - FSM states: IDLE and WAIT_ACK2.
//    IDLE -ack1-> WAIT_ACK2: latch cur_idx = grant_idx, set isr[grant_idx].
//    WAIT_ACK2 -ack2-> IDLE: if aeoi_mode, clear isr[cur_idx], last_idx = cur_idx, last_valid = 1.
//    ack1 in WAIT_ACK2: restart. Re-latch cur_idx and set the new bit; the old bit stays set.
//    ack2 in IDLE: ignored.
//  - Priority order: prio_base, prio_base+1, ..., wrapping modulo NUM_IRQ.
//  - Non-specific EOI: clear the first set isr bit in priority order.
//    If isr = 0: no change, and last_idx / last_valid are held.
//  - Specific EOI: clear isr[eoi_level].
//    eoi_level >= NUM_IRQ is ignored entirely.
//    Clearing an already-clear bit still updates last_idx.
//  - EOI, set and clear are all evaluated on pre-edge isr. If a set and a clear target the same bit in one cycle, the set wins.
//  - Auto-EOI and eoi_cmd in the same cycle: both clears apply. last_idx takes the eoi_cmd index.
//  - isr_top_idx uses the same priority scan as non-specific EOI, recomputed from registered isr and prio_base.
// CONFIGURATION
//  PIC_ROTATE_EN defined:
//    - On an effective EOI with eoi_rotate = 1, prio_base <= (cleared_idx + 1) mod NUM_IRQ next cycle, so the cleared channel becomes lowest priority.
//    - Auto-EOI with aeoi_rotate = 1 rotates the same way.
//    - An ignored EOI does not rotate.
//  PIC_ROTATE_EN undefined:
//    - prio_base is tied to 0; eoi_rotate and aeoi_rotate are ignored.
//    - Fixed priority: IR0 highest, IR(NUM_IRQ-1) lowest.
// TESTING
//  1. reset; ack1 with grant_idx=5, then ack2 with aeoi_mode=0 -> isr=8'h20, FSM back in IDLE, last_valid=0.
//  2. isr=8'h28; non-specific EOI -> isr=8'h20, last_idx=3; second non-specific EOI -> isr=0, last_idx=5.
//  3. aeoi_mode=1; ack1 idx=2, then ack2 -> isr bit 2 is 1 for one cycle then 0, last_idx=2.
//  4. NUM_IRQ=6; specific EOI with eoi_level=7 -> isr, last_idx and prio_base unchanged.
//  5. ack1 idx=4 and specific EOI on 4 in the same cycle, starting from isr=8'h10 -> isr=8'h10 (set wins).
//  6. PIC_ROTATE_EN; isr=8'h41; non-specific EOI with rotate -> isr=8'h40, prio_base=1, isr_top_idx=6; reset -> prio_base=0.

Source files
------------

// File: rtl/pic_isr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pic_isr_ctrl
// Description : In-Service Register controller for an 8259-style PIC.
//               The first INTA pulse (ack1_i) latches grant_idx_i and sets its
//               ISR bit. The second INTA pulse (ack2_i) either leaves the bit
//               set or clears it when auto-EOI is enabled. An OCW2 EOI clears
//               either a named bit (specific) or the highest-priority set bit
//               (non-specific).
//               Optional feature macro: PIC_ROTATE_EN. When it is defined,
//               EOI / auto-EOI can rotate priority so that the cleared channel
//               becomes the lowest priority. When it is not defined, priority
//               is fixed with IR0 highest.
// Ports       : clk_i, reset_i         clock, synchronous active-high reset
//               ack1_i, ack2_i         INTA strobes
//               grant_idx_i            resolver winner, sampled on ack1_i
//               aeoi_mode_i            auto-EOI on ack2_i
//               eoi_cmd_i, eoi_specific_i, eoi_level_i, eoi_rotate_i
//                                      OCW2 EOI command and qualifiers
//               aeoi_rotate_i          rotate priority on auto-EOI
//               isr_o, isr_any_o, isr_top_idx_o
//                                      in-service bits and priority summary
//               last_idx_o, last_valid_o
//                                      most recently cleared index
//               prio_base_o            index currently holding top priority
// Revision    : 1.0 - initial release
// ============================================================================
module pic_isr_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ack1_i,
  input  logic               ack2_i,
  input  logic [IDX_W-1:0]   grant_idx_i,
  input  logic               aeoi_mode_i,
  input  logic               eoi_cmd_i,
  input  logic               eoi_specific_i,
  input  logic [IDX_W-1:0]   eoi_level_i,
  input  logic               eoi_rotate_i,
  input  logic               aeoi_rotate_i,
  output logic [NUM_IRQ-1:0] isr_o,
  output logic               isr_any_o,
  output logic [IDX_W-1:0]   isr_top_idx_o,
  output logic [IDX_W-1:0]   last_idx_o,
  output logic               last_valid_o,
  output logic [IDX_W-1:0]   prio_base_o
);

  localparam logic [0:0]         c_IDLE      = 1'b0;
  localparam logic [0:0]         c_WAIT_ACK2 = 1'b1;
  localparam logic [NUM_IRQ-1:0] c_ONE       = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               last_valid_q, last_valid_d;
  logic [IDX_W-1:0]   prio_base_q, prio_base_d;

  logic               w_top_found;
  logic [IDX_W-1:0]   w_top_idx;
  logic               w_grant_ok;
  logic               w_level_ok;
  logic               w_aeoi_fire;
  logic               w_eoi_fire;
  logic [IDX_W-1:0]   w_eoi_idx;
  logic [NUM_IRQ-1:0] w_set_mask;
  logic [NUM_IRQ-1:0] w_clr_mask;

  // Indices can exceed NUM_IRQ-1 when NUM_IRQ is not a power of two.
  assign w_grant_ok = (int'(grant_idx_i) < NUM_IRQ);
  assign w_level_ok = (int'(eoi_level_i) < NUM_IRQ);

  // Priority scan starting at prio_base_q and wrapping; shared by the
  // non-specific EOI and the isr_top_idx_o output.
  always_comb begin : p_scan
    logic [IDX_W-1:0] pos;
    w_top_found = 1'b0;
    w_top_idx   = '0;
    pos         = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (int'(prio_base_q) + k >= NUM_IRQ) begin
        pos = IDX_W'(int'(prio_base_q) + k - NUM_IRQ);
      end else begin
        pos = IDX_W'(int'(prio_base_q) + k);
      end
      if (!w_top_found && isr_q[pos]) begin
        w_top_found = 1'b1;
        w_top_idx   = pos;
      end
    end
  end

  always_comb begin : p_next
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    w_set_mask   = '0;
    w_clr_mask   = '0;
    w_aeoi_fire  = 1'b0;
    w_eoi_fire   = 1'b0;
    w_eoi_idx    = '0;

    // ack1 restarts the handshake from either state; an older bit stays set.
    if (ack1_i) begin
      state_d   = c_WAIT_ACK2;
      cur_idx_d = grant_idx_i;
      if (w_grant_ok) begin
        w_set_mask = c_ONE << grant_idx_i;
      end
    end else if (ack2_i && (state_q == c_WAIT_ACK2)) begin
      state_d     = c_IDLE;
      w_aeoi_fire = aeoi_mode_i;
    end

    if (eoi_cmd_i) begin
      if (eoi_specific_i) begin
        w_eoi_fire = w_level_ok;
        w_eoi_idx  = eoi_level_i;
      end else begin
        w_eoi_fire = w_top_found;
        w_eoi_idx  = w_top_idx;
      end
    end

    if (w_aeoi_fire) begin
      w_clr_mask = w_clr_mask | (c_ONE << cur_idx_q);
    end
    if (w_eoi_fire) begin
      w_clr_mask = w_clr_mask | (c_ONE << w_eoi_idx);
    end

    // Set is applied after clear so it wins on a shared bit.
    isr_d = (isr_q & ~w_clr_mask) | w_set_mask;

    // An explicit EOI takes precedence over auto-EOI for last_idx.
    if (w_eoi_fire) begin
      last_idx_d   = w_eoi_idx;
      last_valid_d = 1'b1;
    end else if (w_aeoi_fire) begin
      last_idx_d   = cur_idx_q;
      last_valid_d = 1'b1;
    end
  end

`ifdef PIC_ROTATE_EN
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_IRQ - 1);

  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx);
    return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin : p_rotate
    prio_base_d = prio_base_q;
    if (w_eoi_fire && eoi_rotate_i) begin
      prio_base_d = f_next_idx(w_eoi_idx);
    end else if (w_aeoi_fire && aeoi_rotate_i) begin
      prio_base_d = f_next_idx(cur_idx_q);
    end
  end
`else
  logic w_unused_rotate;
  assign w_unused_rotate = eoi_rotate_i ^ aeoi_rotate_i;
  assign prio_base_d     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= c_IDLE;
      cur_idx_q    <= '0;
      isr_q        <= '0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      prio_base_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      isr_q        <= isr_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      prio_base_q  <= prio_base_d;
    end
  end

  assign isr_o         = isr_q;
  assign isr_any_o     = |isr_q;
  assign isr_top_idx_o = w_top_idx;
  assign last_idx_o    = last_idx_q;
  assign last_valid_o  = last_valid_q;
  assign prio_base_o   = prio_base_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_isr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_isr_ctrl
// Description : Self-checking bench for pic_isr_ctrl. Drives an 8-channel and
//               a 6-channel instance with the same strobes and compares both
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_isr_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, ack1_i, ack2_i, aeoi_mode_i;
  logic       eoi_cmd_i, eoi_specific_i, eoi_rotate_i, aeoi_rotate_i;
  logic [2:0] grant_idx_i, eoi_level_i;
  logic [2:0] grant6;

  logic [7:0] isr8;
  logic       any8, lv8;
  logic [2:0] top8, last8, base8;
  logic [5:0] isr6;
  logic       any6, lv6;
  logic [2:0] top6, last6, base6;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = 8-channel unit, 1 = 6-channel unit.
  bit [31:0] m_isr  [2];
  bit        m_wait [2];
  int        m_cur  [2];
  int        m_last [2];
  bit        m_lv   [2];
  int        m_base [2];
  int        nirq   [2] = '{8, 6};

  always #5 clk = ~clk;

  assign grant6 = (grant_idx_i >= 3'd6) ? grant_idx_i - 3'd6 : grant_idx_i;

  pic_isr_ctrl #(.NUM_IRQ(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset_i), .ack1_i(ack1_i), .ack2_i(ack2_i),
    .grant_idx_i(grant_idx_i), .aeoi_mode_i(aeoi_mode_i), .eoi_cmd_i(eoi_cmd_i),
    .eoi_specific_i(eoi_specific_i), .eoi_level_i(eoi_level_i),
    .eoi_rotate_i(eoi_rotate_i), .aeoi_rotate_i(aeoi_rotate_i),
    .isr_o(isr8), .isr_any_o(any8), .isr_top_idx_o(top8), .last_idx_o(last8),
    .last_valid_o(lv8), .prio_base_o(base8)
  );

  pic_isr_ctrl #(.NUM_IRQ(6)) u_dut6 (
    .clk_i(clk), .reset_i(reset_i), .ack1_i(ack1_i), .ack2_i(ack2_i),
    .grant_idx_i(grant6), .aeoi_mode_i(aeoi_mode_i), .eoi_cmd_i(eoi_cmd_i),
    .eoi_specific_i(eoi_specific_i), .eoi_level_i(eoi_level_i),
    .eoi_rotate_i(eoi_rotate_i), .aeoi_rotate_i(aeoi_rotate_i),
    .isr_o(isr6), .isr_any_o(any6), .isr_top_idx_o(top6), .last_idx_o(last6),
    .last_valid_o(lv6), .prio_base_o(base6)
  );

  // First set bit walking from base upward with wraparound, -1 if none.
  function automatic int top_of(input bit [31:0] v, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(base + k) % n]) return (base + k) % n;
    end
    return -1;
  endfunction

  task automatic model_update(input int u);
    int  n, g, t, eidx;
    bit  aeoi, eff;
    bit [31:0] nxt;
    n = nirq[u];
    g = (u == 0) ? int'(grant_idx_i) : int'(grant_idx_i) % 6;
    if (reset_i) begin
      m_isr[u] = 0; m_wait[u] = 0; m_cur[u] = 0;
      m_last[u] = 0; m_lv[u] = 0; m_base[u] = 0;
      return;
    end
    nxt  = m_isr[u];
    aeoi = m_wait[u] && ack2_i && !ack1_i && aeoi_mode_i;
    eff  = 0;
    eidx = 0;
    if (aeoi) nxt[m_cur[u]] = 1'b0;
    if (eoi_cmd_i) begin
      if (eoi_specific_i) begin
        if (int'(eoi_level_i) < n) begin eff = 1; eidx = int'(eoi_level_i); end
      end else begin
        t = top_of(m_isr[u], m_base[u], n);
        if (t >= 0) begin eff = 1; eidx = t; end
      end
    end
    if (eff) nxt[eidx] = 1'b0;
    if (ack1_i) nxt[g] = 1'b1;
    if (eff) begin m_last[u] = eidx; m_lv[u] = 1; end
    else if (aeoi) begin m_last[u] = m_cur[u]; m_lv[u] = 1; end
`ifdef PIC_ROTATE_EN
    if (eff && eoi_rotate_i) m_base[u] = (eidx + 1) % n;
    else if (aeoi && aeoi_rotate_i) m_base[u] = (m_cur[u] + 1) % n;
`endif
    if (ack1_i) begin m_wait[u] = 1; m_cur[u] = g; end
    else if (ack2_i) m_wait[u] = 0;
    m_isr[u] = nxt;
  endtask

  task automatic idle_inputs();
    reset_i = 0; ack1_i = 0; ack2_i = 0; aeoi_mode_i = 0;
    eoi_cmd_i = 0; eoi_specific_i = 0; eoi_rotate_i = 0; aeoi_rotate_i = 0;
    grant_idx_i = 0; eoi_level_i = 0;
  endtask

  // Apply current inputs across one edge, keeping the model in step.
  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1; ack1_i = 1; grant_idx_i = 3; eoi_cmd_i = 1;
    step();
    checks++;
    if ({isr8, any8, top8, last8, lv8, base8} !== 19'd0) begin
      errors++; $display("FAIL reset8 got isr=%h any=%b top=%0d last=%0d lv=%b base=%0d want all 0",
                         isr8, any8, top8, last8, lv8, base8);
    end
    checks++;
    if ({isr6, any6, top6, last6, lv6, base6} !== 17'd0) begin
      errors++; $display("FAIL reset6 got isr=%h lv=%b want all 0", isr6, lv6);
    end
  endtask

  task automatic test_no_aeoi();
    do_reset();
    ack1_i = 1; grant_idx_i = 5; step();
    ack2_i = 1; aeoi_mode_i = 0; step();
    checks++;
    if (isr8 !== 8'h20 || lv8 !== 1'b0) begin
      errors++; $display("FAIL no_aeoi got isr=%h lv=%b want 20 0", isr8, lv8);
    end
    // Back in IDLE: a stray ack2 with auto-EOI on must not clear anything.
    ack2_i = 1; aeoi_mode_i = 1; step();
    checks++;
    if (isr8 !== 8'h20 || lv8 !== 1'b0 || top8 !== 3'd5) begin
      errors++; $display("FAIL idle_ack2 got isr=%h lv=%b top=%0d want 20 0 5", isr8, lv8, top8);
    end
  endtask

  task automatic test_nonspecific();
    ack1_i = 1; grant_idx_i = 3; step();
    ack2_i = 1; step();
    checks++;
    if (isr8 !== 8'h28 || top8 !== 3'd3 || any8 !== 1'b1) begin
      errors++; $display("FAIL ns_setup got isr=%h top=%0d want 28 3", isr8, top8);
    end
    eoi_cmd_i = 1; step();
    checks++;
    if (isr8 !== 8'h20 || last8 !== 3'd3 || lv8 !== 1'b1) begin
      errors++; $display("FAIL ns_eoi1 got isr=%h last=%0d want 20 3", isr8, last8);
    end
    eoi_cmd_i = 1; step();
    checks++;
    if (isr8 !== 8'h00 || last8 !== 3'd5 || any8 !== 1'b0 || top8 !== 3'd0) begin
      errors++; $display("FAIL ns_eoi2 got isr=%h last=%0d any=%b want 00 5 0", isr8, last8, any8);
    end
    eoi_cmd_i = 1; step();
    checks++;
    if (isr8 !== 8'h00 || last8 !== 3'd5 || lv8 !== 1'b1) begin
      errors++; $display("FAIL ns_empty got isr=%h last=%0d lv=%b want 00 5 1", isr8, last8, lv8);
    end
  endtask

  task automatic test_aeoi();
    do_reset();
    aeoi_mode_i = 1; ack1_i = 1; grant_idx_i = 2; step();
    checks++;
    if (isr8 !== 8'h04) begin
      errors++; $display("FAIL aeoi_set got isr=%h want 04", isr8);
    end
    aeoi_mode_i = 1; ack2_i = 1; step();
    checks++;
    if (isr8 !== 8'h00 || last8 !== 3'd2 || lv8 !== 1'b1) begin
      errors++; $display("FAIL aeoi_clr got isr=%h last=%0d lv=%b want 00 2 1", isr8, last8, lv8);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    ack1_i = 1; grant_idx_i = 3; step();
    ack2_i = 1; step();
    eoi_cmd_i = 1; eoi_specific_i = 1; eoi_level_i = 7; eoi_rotate_i = 1; step();
    eoi_cmd_i = 1; eoi_specific_i = 1; eoi_level_i = 6; eoi_rotate_i = 1; step();
    checks++;
    if (isr6 !== 6'h08 || last6 !== 3'd0 || lv6 !== 1'b0 || base6 !== 3'd0) begin
      errors++; $display("FAIL oor_ignore got isr=%h last=%0d lv=%b base=%0d want 08 0 0 0",
                         isr6, last6, lv6, base6);
    end
    eoi_cmd_i = 1; eoi_specific_i = 1; eoi_level_i = 3; step();
    checks++;
    if (isr6 !== 6'h00 || last6 !== 3'd3 || lv6 !== 1'b1) begin
      errors++; $display("FAIL oor_valid got isr=%h last=%0d want 00 3", isr6, last6);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    ack1_i = 1; grant_idx_i = 4; step();
    ack2_i = 1; step();
    ack1_i = 1; grant_idx_i = 4; eoi_cmd_i = 1; eoi_specific_i = 1; eoi_level_i = 4; step();
    checks++;
    if (isr8 !== 8'h10 || last8 !== 3'd4 || lv8 !== 1'b1) begin
      errors++; $display("FAIL set_wins got isr=%h last=%0d want 10 4", isr8, last8);
    end
  endtask

  task automatic test_rotate();
    int exp_base;
`ifdef PIC_ROTATE_EN
    exp_base = 1;
`else
    exp_base = 0;
`endif
    do_reset();
    ack1_i = 1; grant_idx_i = 0; step();
    ack2_i = 1; step();
    ack1_i = 1; grant_idx_i = 6; step();
    ack2_i = 1; step();
    checks++;
    if (isr8 !== 8'h41 || top8 !== 3'd0) begin
      errors++; $display("FAIL rot_setup got isr=%h top=%0d want 41 0", isr8, top8);
    end
    eoi_cmd_i = 1; eoi_rotate_i = 1; step();
    checks++;
    if (isr8 !== 8'h40 || int'(base8) !== exp_base || top8 !== 3'd6 || last8 !== 3'd0) begin
      errors++; $display("FAIL rot_eoi got isr=%h base=%0d top=%0d want 40 %0d 6",
                         isr8, base8, top8, exp_base);
    end
    do_reset();
    checks++;
    if (base8 !== 3'd0) begin
      errors++; $display("FAIL rot_reset got base=%0d want 0", base8);
    end
  endtask

  task automatic test_random();
    int r, et;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 9);
      ack1_i         = (r < 3);
      ack2_i         = (r >= 3 && r < 6);
      grant_idx_i    = 3'($urandom_range(0, 7));
      aeoi_mode_i    = 1'($urandom_range(0, 1));
      eoi_cmd_i      = ($urandom_range(0, 2) == 0);
      eoi_specific_i = 1'($urandom_range(0, 1));
      eoi_level_i    = 3'($urandom_range(0, 7));
      eoi_rotate_i   = 1'($urandom_range(0, 1));
      aeoi_rotate_i  = 1'($urandom_range(0, 1));
      reset_i        = ($urandom_range(0, 99) == 0);
      step();
      for (int u = 0; u < 2; u++) begin
        bit [7:0] a_isr;
        bit [2:0] a_top, a_last, a_base;
        bit       a_any, a_lv;
        a_isr  = (u == 0) ? isr8  : {2'b00, isr6};
        a_any  = (u == 0) ? any8  : any6;
        a_top  = (u == 0) ? top8  : top6;
        a_last = (u == 0) ? last8 : last6;
        a_lv   = (u == 0) ? lv8   : lv6;
        a_base = (u == 0) ? base8 : base6;
        et = top_of(m_isr[u], m_base[u], nirq[u]);
        if (et < 0) et = 0;
        checks++;
        if (a_isr !== m_isr[u][7:0] || a_any !== (m_isr[u] != 0)) begin
          errors++; $display("FAIL rnd_isr u%0d cyc %0d got %h want %h", u, cyc, a_isr, m_isr[u][7:0]);
        end
        checks++;
        if (int'(a_top) !== et) begin
          errors++; $display("FAIL rnd_top u%0d cyc %0d got %0d want %0d", u, cyc, a_top, et);
        end
        checks++;
        if (int'(a_last) !== m_last[u] || a_lv !== m_lv[u]) begin
          errors++; $display("FAIL rnd_last u%0d cyc %0d got %0d/%b want %0d/%b",
                             u, cyc, a_last, a_lv, m_last[u], m_lv[u]);
        end
        checks++;
        if (int'(a_base) !== m_base[u]) begin
          errors++; $display("FAIL rnd_base u%0d cyc %0d got %0d want %0d", u, cyc, a_base, m_base[u]);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_no_aeoi();
    test_nonspecific();
    test_aeoi();
    test_out_of_range();
    test_set_wins();
    test_rotate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
